// File: rtl/sar_pkg.sv
// Shared definitions for the SAR search controller.
//   DEF_WIDTH : default operand width
//   MAX_ITER  : worst-case SEARCH cycles for a well-behaved comparator
//   state_t   : controller FSM states
package sar_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int MAX_ITER  = DEF_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/sar_search_ctrl.sv
// Binary-search initiator for a magnitude comparator.
// Drives a candidate onto the comparator b operand. It narrows [lo,hi] using
// the gt/lt/eq response until it finds the hidden a operand.
// Ports:
//   clk, rst          : clock, async active-high reset
//   start             : begin a search (sampled in IDLE only)
//   cand              : registered candidate to comparator b operand
//   cmp_gt/lt/eq      : comparator response for the current cand
//   busy              : high while searching
//   done              : one-cycle pulse at end of search
//   result            : matched value, held until next match/reset
//   err               : protocol/bound fault flag, held until next start
module sar_search_ctrl
  import sar_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] cand,
  input  logic             cmp_gt,
  input  logic             cmp_lt,
  input  logic             cmp_eq,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] MID      = ALL_ONES >> 1;
  localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);
  localparam logic [WIDTH:0]   ONE_X    = (WIDTH+1)'(1);

  state_t           state;
  logic [WIDTH-1:0] lo, hi;

  // Midpoints are formed one bit wider so cand+1+hi at the top of the range
  // cannot wrap before the divide by two.
  logic [WIDTH:0] up_sum, dn_sum;

  always_comb begin
    up_sum = {1'b0, cand} + ONE_X + {1'b0, hi};
    dn_sum = {1'b0, lo} + {1'b0, cand} - ONE_X;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      lo     <= '0;
      hi     <= ALL_ONES;
      cand   <= '0;
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            state <= SEARCH;
            busy  <= 1'b1;
            lo    <= '0;
            hi    <= ALL_ONES;
            cand  <= MID;
            err   <= 1'b0;
          end
        end

        SEARCH: begin
          // Exactly one response bit must be set; anything else is a fault.
          case ({cmp_gt, cmp_lt, cmp_eq})
            3'b001: begin
              result <= cand;
              state  <= FINISH;
              busy   <= 1'b0;
              done   <= 1'b1;
            end
            3'b100: begin
              if (cand == hi) begin
                err   <= 1'b1;
                state <= FINISH;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                lo   <= cand + ONE_W;
                cand <= up_sum[WIDTH:1];
              end
            end
            3'b010: begin
              if (cand == lo) begin
                err   <= 1'b1;
                state <= FINISH;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                hi   <= cand - ONE_W;
                cand <= dn_sum[WIDTH:1];
              end
            end
            default: begin
              err   <= 1'b1;
              state <= FINISH;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          endcase
        end

        FINISH: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Self-checking bench for sar_search_ctrl: behavioural comparator with fault
// injection, reference search model feeding a scoreboard queue.
module tb_sar_search_ctrl;
  import sar_pkg::*;

  localparam int W = DEF_WIDTH;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] cand, result;
  logic         cmp_gt, cmp_lt, cmp_eq;
  logic         busy, done, err;

  logic [W-1:0] target = '0;
  int           fault = 0;   // 0 clean, 1 lt stuck high, 2 gt+eq both high

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [W-1:0] result;
    logic         err;
    int           cycles;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] cq[$];
  logic [W-1:0] last_result = '0;

  sar_search_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .cand(cand),
    .cmp_gt(cmp_gt), .cmp_lt(cmp_lt), .cmp_eq(cmp_eq),
    .busy(busy), .done(done), .result(result), .err(err)
  );

  always #5 clk = ~clk;

  // Comparator: a = target, b = cand.
  always_comb begin
    cmp_gt = target > cand;
    cmp_lt = target < cand;
    cmp_eq = target == cand;
    if (fault == 1) begin
      cmp_gt = 1'b0; cmp_lt = 1'b1; cmp_eq = 1'b0;
    end else if (fault == 2) begin
      cmp_gt = 1'b1; cmp_lt = 1'b0; cmp_eq = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference search: expected candidate sequence plus final outcome.
  task automatic model(input logic [W-1:0] tgt, input int flt, output exp_t e);
    logic [W:0] lo, hi, c;
    logic g, l, q;
    lo = 0; hi = (1 << W) - 1; c = hi >> 1;
    e.result = last_result; e.err = 1'b0; e.cycles = 0;
    for (int k = 0; k < 3 * W; k++) begin
      e.cycles++;
      cq.push_back(c[W-1:0]);
      g = tgt > c[W-1:0]; l = tgt < c[W-1:0]; q = tgt == c[W-1:0];
      if (flt == 1) begin g = 0; l = 1; q = 0; end
      if (flt == 2) begin g = 1; l = 0; q = 1; end
      if ((g + l + q) != 1) begin e.err = 1; break; end
      if (q) begin e.result = c[W-1:0]; break; end
      if (g) begin
        if (c == hi) begin e.err = 1; break; end
        lo = c + 1; c = (lo + hi) >> 1;
      end else begin
        if (c == lo) begin e.err = 1; break; end
        hi = c - 1; c = (lo + hi) >> 1;
      end
    end
    last_result = e.result;
  endtask

  task automatic run(input logic [W-1:0] tgt, input int flt, input bit poke, output int n);
    exp_t e;
    bit   got;
    target = tgt; fault = flt;
    model(tgt, flt, e);
    sb.push_back(e);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    n = 0; got = 0;
    for (int k = 0; k < MAX_ITER + 4; k++) begin
      if (done) begin got = 1; break; end
      if (busy) begin
        n++;
        if (cq.size() > 0) chk("cand_seq", cand, cq.pop_front());
        else chk("extra_cycle", n, e.cycles);
      end
      start = (poke && n == 3);
      @(negedge clk);
    end
    start = 1'b0;
    chk("done_seen", got, 1);
    e = sb.pop_front();
    if (got) begin
      chk("result", result, e.result);
      chk("err", err, e.err);
      chk("cycles", n, e.cycles);
      chk("busy_at_done", busy, 0);
      if (flt == 0) chk("cycle_bound", n <= MAX_ITER, 1);
      @(negedge clk);
      chk("done_one_cycle", done, 0);
    end
    cq.delete();
  endtask

  initial begin
    int  n;
    bit  saw_done;
    @(negedge clk);
    chk("rst_cand", cand, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_result", result, 0);
    rst = 1'b0;
    @(negedge clk);

    run(16'h7FFF, 0, 0, n); chk("mid_cycles", n, 1);
    run(16'hFFFF, 0, 0, n); chk("top_cycles", n, 17);
    run(16'h0000, 0, 0, n);
    run(16'h1234, 0, 1, n);          // start poked while busy is ignored
    run(16'h4000, 1, 0, n); chk("lt_stuck_cand", cand, 0);
    run(16'h4000, 2, 0, n); chk("gt_eq_cycles", n, 1);
    run(16'hABCD, 0, 0, n);          // err clears on a fresh start

    // Abort by reset after 5 SEARCH cycles.
    target = 16'h0123; fault = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_abort_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_cand", cand, 0);
    chk("abort_done", done, 0);
    chk("abort_result", result, 0);
    last_result = '0;
    saw_done = 0;
    @(negedge clk) rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done) saw_done = 1;
    end
    chk("abort_no_done", saw_done, 0);
    run(16'h0123, 0, 0, n);

    for (int i = 0; i < 1000; i++) run(W'($urandom_range(0, 65535)), 0, 0, n);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
